aes_cipher_arbiter: RTL and testbench

- Shares one combinational AES-128 cipher core (128-bit key and data in, 128-bit ciphertext out) among NUM_REQ requesters.
- Round-robin arbitration, registered core operands, and a CORE_LAT-cycle multicycle wait before the core result is sampled.
- The ciphertext is returned to the granted requester over a valid/ready response channel.
- Sits between the encryption clients and the cipher instance in the AES subsystem.

---
 rtl/aes_cipher_arbiter.sv | 120 ++++++++++++
 tb/tb_aes_cipher_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_arbiter.sv
// aes_cipher_arbiter: shares one combinational AES-128 core among NUM_REQ
// requesters. Arbitration is round-robin. The core operands are registered and
// held for CORE_LAT cycles before the core result is captured. The ciphertext is
// then returned to the granted requester over a valid/ready channel.
module aes_cipher_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int CORE_LAT = 2,
  localparam int IDW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW       = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*128-1:0] req_key,
  input  logic [NUM_REQ*128-1:0] req_data,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [127:0]           rsp_data,
  output logic [127:0]           core_key,
  output logic [127:0]           core_data,
  input  logic [127:0]           core_o,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [CW-1:0]  cnt;
  logic           found;
  logic [IDW-1:0] winner;
  logic [127:0]   key_arr  [NUM_REQ];
  logic [127:0]   data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign key_arr[g]  = req_key[128*g +: 128];
    assign data_arr[g] = req_data[128*g +: 128];
  end

  // Round-robin search: lowest valid index above ptr wins, else lowest valid index at or below ptr
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) <= ptr)) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) > ptr)) begin
        found  = 1'b1;
        winner = IDW'(i);
      end
    end
  end

  // Handshake strobes: ready to the winner only while idle, valid to the granted requester while responding
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (state == IDLE && found) begin
      req_ready[winner] = 1'b1;
    end
    if (state == RESP) begin
      rsp_valid[grant_id] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Grant and capture operands, hold them for CORE_LAT cycles, then hold the ciphertext until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IDW'(NUM_REQ - 1);
      grant_id  <= '0;
      cnt       <= '0;
      core_key  <= '0;
      core_data <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            core_key  <= key_arr[winner];
            core_data <= data_arr[winner];
            ptr       <= winner;
            grant_id  <= winner;
            cnt       <= CW'(CORE_LAT - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            rsp_data <= core_o;
            state    <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[grant_id]) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_arbiter.sv
// tb_aes_cipher_arbiter: drives the arbiter with a reference AES-128 model as its core and
// checks grants, timing, handshakes and ciphertexts against a scoreboard.
module tb_aes_cipher_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [511:0] req_key, req_data;
  logic [127:0] rsp_data, core_key, core_data, core_o;
  logic         busy;
  logic [1:0]   grant_id;

  logic [3:0]   req_valid1, req_ready1, rsp_valid1, rsp_ready1;
  logic [511:0] req_key1, req_data1;
  logic [127:0] rsp_data1, core_key1, core_data1, core_o1;
  logic         busy1;
  logic [1:0]   grant_id1;

  logic [127:0] key_tab  [4];
  logic [127:0] data_tab [4];

  typedef struct {
    logic [1:0]   id;
    logic [127:0] data;
  } exp_t;

  exp_t exp_q [$];

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int acc_cyc      = 0;

  int           s_cyc;
  logic [3:0]   s_req_ready, s_rsp_valid, s1_req_ready, s1_rsp_valid, prev_rsp;
  logic [127:0] s_rsp_data, s_core_key, s_core_data, s1_rsp_data;
  logic         s_busy, s1_busy, s_acc;
  logic [1:0]   s_grant_id;
  int           s_acc_id;

  aes_cipher_arbiter #(.NUM_REQ(4), .CORE_LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .core_key(core_key), .core_data(core_data), .core_o(core_o),
    .busy(busy), .grant_id(grant_id)
  );

  aes_cipher_arbiter #(.NUM_REQ(4), .CORE_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_key(req_key1), .req_data(req_data1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .core_key(core_key1), .core_data(core_data1), .core_o(core_o1),
    .busy(busy1), .grant_id(grant_id1)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pack the per-requester operand tables onto the wide request buses
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_key[128*i +: 128]  = key_tab[i];
      req_data[128*i +: 128] = data_tab[i];
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, r;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0]), sbox(tmp[31:24])} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox(s[i]);
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) s[q+4*c] = t[q+4*((c+q)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Reference cipher core for the CORE_LAT=2 instance
  always_comb core_o = aes128(core_key, core_data);

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] ready);
    req_valid = valid;
    rsp_ready = ready;
  endtask

  task automatic monitor();
    exp_t e;
    s_cyc        = cyc;
    s_req_ready  = req_ready;
    s_rsp_valid  = rsp_valid;
    s_rsp_data   = rsp_data;
    s_core_key   = core_key;
    s_core_data  = core_data;
    s_busy       = busy;
    s_grant_id   = grant_id;
    s1_req_ready = req_ready1;
    s1_rsp_valid = rsp_valid1;
    s1_rsp_data  = rsp_data1;
    s1_busy      = busy1;
    s_acc        = 1'b0;
    if (rst) begin
      exp_q.delete();
      prev_rsp = '0;
      return;
    end
    checkOutput("ready_onehot", $onehot0(req_ready), 1'b1);
    checkOutput("valid_onehot", $onehot0(rsp_valid), 1'b1);
    checkOutput("ready_without_valid", req_ready & ~req_valid, 4'b0);
    if ((req_ready & req_valid) != '0) begin
      for (int i = 0; i < 4; i++) if (req_ready[i] && req_valid[i]) s_acc_id = i;
      s_acc   = 1'b1;
      acc_cyc = cyc;
      e.id    = 2'(s_acc_id);
      e.data  = aes128(key_tab[s_acc_id], data_tab[s_acc_id]);
      exp_q.push_back(e);
    end
    if (rsp_valid != '0 && prev_rsp == '0) begin
      checkOutput("rsp_latency", cyc - acc_cyc, 3);
      checkOutput("rsp_pending", exp_q.size() != 0, 1'b1);
    end
    if ((rsp_valid & rsp_ready) != '0 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checkOutput("rsp_id", rsp_valid, 4'b0001 << e.id);
      checkOutput("rsp_data", rsp_data, e.data);
    end
    prev_rsp = rsp_valid;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitAccept(input string tag, input int budget, output int id, output int at);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_acc && n < budget);
    checkOutput(tag, s_acc, 1'b1);
    id = s_acc_id;
    at = s_cyc;
  endtask

  task automatic waitRsp(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (s_rsp_valid == '0 && n < budget);
    checkOutput(tag, s_rsp_valid != '0, 1'b1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
    checkOutput("drain_empty", exp_q.size(), 0);
  endtask

  // Directed sequence of scenarios
  initial begin
    int id, at, prev_at;
    logic [127:0] held;
    logic flag;
    rst = 1'b1;
    prev_rsp = '0;
    for (int i = 0; i < 4; i++) begin
      key_tab[i]  = '0;
      data_tab[i] = '0;
    end
    applyStimulus(4'b0000, 4'b1111);
    req_valid1 = '0;
    rsp_ready1 = 4'b1111;
    req_key1   = '0;
    req_data1  = '0;
    core_o1    = '0;
    tick();
    tick();
    rst = 1'b0;

    tick();
    checkOutput("reset_req_ready", s_req_ready, 4'b0);
    checkOutput("reset_rsp_valid", s_rsp_valid, 4'b0);
    checkOutput("reset_busy", s_busy, 1'b0);
    checkOutput("reset_core_key", s_core_key, 128'h0);
    checkOutput("reset_core_data", s_core_data, 128'h0);
    checkOutput("reset_rsp_data", s_rsp_data, 128'h0);
    checkOutput("reset_grant_id", s_grant_id, 2'd0);

    $display("[TB] single request, known AES vector");
    key_tab[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    data_tab[0] = 128'h00112233445566778899aabbccddeeff;
    applyStimulus(4'b0001, 4'b1111);
    waitAccept("t1_accept", 4, id, at);
    checkOutput("t1_grant", id, 0);
    applyStimulus(4'b0000, 4'b1111);
    tick();
    checkOutput("t1_busy_a1", s_busy, 1'b1);
    checkOutput("t1_core_key", s_core_key, 128'h000102030405060708090a0b0c0d0e0f);
    checkOutput("t1_core_data", s_core_data, 128'h00112233445566778899aabbccddeeff);
    checkOutput("t1_no_rsp_a1", s_rsp_valid, 4'b0);
    tick();
    checkOutput("t1_busy_a2", s_busy, 1'b1);
    checkOutput("t1_no_rsp_a2", s_rsp_valid, 4'b0);
    tick();
    checkOutput("t1_rsp_valid", s_rsp_valid, 4'b0001);
    checkOutput("t1_rsp_data", s_rsp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    checkOutput("t1_busy_rsp", s_busy, 1'b1);
    tick();
    checkOutput("t1_idle_busy", s_busy, 1'b0);
    checkOutput("t1_idle_rsp", s_rsp_valid, 4'b0);

    $display("[TB] all four requesters valid");
    for (int i = 0; i < 4; i++) begin
      key_tab[i]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      data_tab[i] = {$urandom, $urandom, $urandom, $urandom};
    end
    rst = 1'b1;
    applyStimulus(4'b1111, 4'b1111);
    tick();
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      waitAccept("t2_accept", 8, id, at);
      checkOutput("t2_grant", id, g % 4);
    end
    applyStimulus(4'b0000, 4'b1111);
    drain(5);

    $display("[TB] requesters 0 and 2 contending");
    rst = 1'b1;
    applyStimulus(4'b0101, 4'b1111);
    tick();
    rst = 1'b0;
    waitAccept("t3_accept", 8, id, prev_at);
    checkOutput("t3_grant", id, 0);
    for (int g = 1; g < 4; g++) begin
      waitAccept("t3_accept", 8, id, at);
      checkOutput("t3_grant", id, (g % 2) * 2);
      checkOutput("t3_spacing", at - prev_at, 4);
      prev_at = at;
    end
    applyStimulus(4'b0000, 4'b1111);
    drain(5);

    $display("[TB] response backpressure");
    rst = 1'b1;
    applyStimulus(4'b0010, 4'b1101);
    tick();
    rst = 1'b0;
    waitAccept("t4_accept", 4, id, at);
    checkOutput("t4_grant", id, 1);
    applyStimulus(4'b0001, 4'b1101);
    waitRsp("t4_rsp", 6);
    held = s_rsp_data;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      checkOutput("t4_hold_valid", s_rsp_valid, 4'b0010);
      checkOutput("t4_hold_data", s_rsp_data, held);
      checkOutput("t4_hold_no_ready", s_req_ready, 4'b0);
      checkOutput("t4_hold_busy", s_busy, 1'b1);
    end
    applyStimulus(4'b0001, 4'b1111);
    tick();
    checkOutput("t4_release_no_grant", s_req_ready, 4'b0);
    tick();
    checkOutput("t4_next_accept", s_acc, 1'b1);
    checkOutput("t4_next_grant", s_acc_id, 0);
    applyStimulus(4'b0000, 4'b1111);
    drain(5);

    $display("[TB] reset while waiting on the core");
    applyStimulus(4'b0001, 4'b1111);
    waitAccept("t5_accept", 4, id, at);
    checkOutput("t5_grant", id, 0);
    rst = 1'b1;
    applyStimulus(4'b1000, 4'b1111);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("t5_busy", s_busy, 1'b0);
    checkOutput("t5_rsp_valid", s_rsp_valid, 4'b0);
    checkOutput("t5_core_key", s_core_key, 128'h0);
    checkOutput("t5_core_data", s_core_data, 128'h0);
    checkOutput("t5_rsp_data", s_rsp_data, 128'h0);
    checkOutput("t5_grant_id", s_grant_id, 2'd0);
    checkOutput("t5_pending_accept", s_acc, 1'b1);
    checkOutput("t5_pending_grant", s_acc_id, 3);
    applyStimulus(4'b0000, 4'b1111);
    flag = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      flag = flag | s_rsp_valid[0];
    end
    checkOutput("t5_no_abandoned_rsp", flag, 1'b0);
    checkOutput("t5_drain_empty", exp_q.size(), 0);

    $display("[TB] CORE_LAT=1 build with a glitching core");
    req_valid1 = 4'b0100;
    core_o1    = 128'hdeadbeef_00000000_11111111_22222222;
    tick();
    checkOutput("t6_accept", s1_req_ready, 4'b0100);
    req_valid1 = 4'b0000;
    core_o1    = 128'h0badf00d_33333333_44444444_55555555;
    #2;
    core_o1    = 128'hcafef00d_01234567_89abcdef_a5a5a5a5;
    tick();
    checkOutput("t6_no_rsp_yet", s1_rsp_valid, 4'b0);
    checkOutput("t6_busy", s1_busy, 1'b1);
    core_o1 = 128'hffffffff_66666666_77777777_88888888;
    tick();
    checkOutput("t6_rsp_valid", s1_rsp_valid, 4'b0100);
    checkOutput("t6_rsp_data", s1_rsp_data, 128'hcafef00d_0123456789abcdef_a5a5a5a5);
    core_o1 = 128'h12345678_9abcdef0_0fedcba9_87654321;
    tick();
    checkOutput("t6_idle_rsp", s1_rsp_valid, 4'b0);
    checkOutput("t6_idle_busy", s1_busy, 1'b0);
    checkOutput("t6_data_held", s1_rsp_data, 128'hcafef00d_0123456789abcdef_a5a5a5a5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
